led_shifter_param: RTL and testbench

//  Parametrised LED shift/rotate register driven by debounced button rising-edge pulses.

---
 rtl/led_pkg.sv | 39 +++
 rtl/led_shifter_param_tick_gen.sv | 18 +
 rtl/led_shifter_param.sv | 88 ++++++++
 tb/tb_led_shifter_param.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: mode encodings and 7-segment helpers shared by the LED shifter
package led_pkg;
  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_FREEZE = 2'b10
  } mode_e;

  function automatic logic [7:0] seg_hex(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  // Callers zero-extend the LED word; WIDTH <= 15 keeps the count within 4 bits.
  function automatic logic [3:0] popcount(input logic [15:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 4'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/led_shifter_param_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle tick every DIV clocks
module tick_gen #(
  parameter int DIV      = 50000000,
  parameter int DIV_BITS = 26
) (
  input  logic clk,
  input  logic async_reset_debounced,
  input  logic clear,
  output logic tick
);
  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  assign tick  = cnt_q == DIV_BITS'(DIV - 1);
  assign cnt_d = (clear || tick) ? '0 : cnt_q + DIV_BITS'(1);
  // Prescaler register; clear restarts the period so the first tick lands DIV cycles later
  always_ff @(posedge clk or negedge async_reset_debounced)
    if (!async_reset_debounced) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/led_shifter_param.sv
// led_shifter_param: button-driven LED shift/rotate register with fill counter and 7-seg status
module led_shifter_param
  import led_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIV      = 50000000,
  parameter int DIV_BITS = 26
) (
  input  logic             clk,
  input  logic             async_reset_debounced,
  input  logic             btn_0_re,
  input  logic             btn_1_re,
  input  logic             btn_mode_re,
  input  logic             direction_debounced,
  input  logic             parity_debounced,
  input  logic             seg_enable_debounced,
  output logic [WIDTH-1:0] led_output,
  output logic [7:0]       segment_output,
  output logic [1:0]       mode_output,
  output logic             full_output
);
  localparam logic [3:0] FULL = 4'(WIDTH);
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] led_q, led_d, shifted, rotated;
  logic [3:0]       fill_q, fill_d;
  logic [7:0]       seg_q, seg_d;
  logic             tick;

  tick_gen #(.DIV(DIV), .DIV_BITS(DIV_BITS)) u_tick (
    .clk                  (clk),
    .async_reset_debounced(async_reset_debounced),
    .clear                (mode_d != mode_q),
    .tick                 (tick)
  );

  assign shifted = direction_debounced ? {btn_1_re, led_q[WIDTH-1:1]} : {led_q[WIDTH-2:0], btn_1_re};
  assign rotated = direction_debounced ? {led_q[0], led_q[WIDTH-1:1]} : {led_q[WIDTH-2:0], led_q[WIDTH-1]};

  // Mode sequencing and LED/fill next state; a mode press masks bit buttons and the tick
  always_comb begin
    mode_d = mode_q;
    led_d  = led_q;
    fill_d = fill_q;
    case (mode_q)
      MODE_SHIFT:
        if (btn_mode_re) mode_d = MODE_ROTATE;
        else if (btn_0_re && btn_1_re) begin
          led_d  = '0;
          fill_d = '0;
        end else if (btn_0_re ^ btn_1_re) begin
          led_d  = shifted;
          fill_d = (fill_q == FULL) ? fill_q : fill_q + 4'd1;
        end
      MODE_ROTATE:
        if (btn_mode_re) mode_d = MODE_FREEZE;
        else if (tick) led_d = rotated;
      MODE_FREEZE:
        if (btn_mode_re) mode_d = MODE_SHIFT;
      default: mode_d = MODE_SHIFT;
    endcase
  end

  // Status digit decoded from the current LED word, registered for one cycle of latency
  always_comb begin
    seg_d = !seg_enable_debounced ? 8'h00 :
            parity_debounced      ? ((^led_q) ? 8'h06 : 8'h3F) :
                                    seg_hex(popcount(16'(led_q)));
  end

  // State registers; reset drops everything back to power-up values immediately
  always_ff @(posedge clk or negedge async_reset_debounced)
    if (!async_reset_debounced) begin
      mode_q <= MODE_SHIFT;
      led_q  <= '0;
      fill_q <= '0;
      seg_q  <= 8'h00;
    end else begin
      mode_q <= mode_d;
      led_q  <= led_d;
      fill_q <= fill_d;
      seg_q  <= seg_d;
    end

  assign led_output     = led_q;
  assign segment_output = seg_q;
  assign mode_output    = mode_q;
  assign full_output    = fill_q == FULL;
endmodule

// File: tb/tb_led_shifter_param.sv
// tb_led_shifter_param: directed scoreboard bench for the LED shifter (WIDTH=8, DIV=4)
module tb_led_shifter_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       b0 = 1'b0, b1 = 1'b0, bm = 1'b0;
  logic       dir = 1'b0, par = 1'b1, segen = 1'b1;
  logic [7:0] led, seg;
  logic [1:0] mode;
  logic       full;

  typedef struct {
    int         kind;
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t       q[$];
  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] led_m = 8'h00;

  led_shifter_param #(.WIDTH(8), .DIV(4), .DIV_BITS(3)) dut (
    .clk                  (clk),
    .async_reset_debounced(rst_n),
    .btn_0_re             (b0),
    .btn_1_re             (b1),
    .btn_mode_re          (bm),
    .direction_debounced  (dir),
    .parity_debounced     (par),
    .seg_enable_debounced (segen),
    .led_output           (led),
    .segment_output       (seg),
    .mode_output          (mode),
    .full_output          (full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input string tag, input logic [7:0] val);
    exp_t e;
    e.kind = kind;
    e.tag  = tag;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t       e;
    logic [7:0] obs;
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = (e.kind == 0) ? led : (e.kind == 1) ? seg : (e.kind == 2) ? {6'b0, mode} : {7'b0, full};
      n_assert++;
      assert (obs === e.val)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic ins(input logic b, input string tag);
    led_m = dir ? {b, led_m[7:1]} : {led_m[6:0], b};
    b0 = ~b;
    b1 = b;
    push(0, tag, led_m);
    step();
    b0 = 1'b0;
    b1 = 1'b0;
    check();
  endtask

  task automatic clr();
    led_m = 8'h00;
    b0 = 1'b1;
    b1 = 1'b1;
    push(0, "clear_led", 8'h00);
    push(3, "clear_full", 8'h00);
    step();
    b0 = 1'b0;
    b1 = 1'b0;
    check();
  endtask

  task automatic mode_press(input logic with_b1, input logic [1:0] m, input string tag);
    bm = 1'b1;
    b1 = with_b1;
    push(2, tag, {6'b0, m});
    push(0, {tag, "_led"}, led_m);
    step();
    bm = 1'b0;
    b1 = 1'b0;
    check();
  endtask

  task automatic rot_period(input string tag);
    for (int i = 0; i < 3; i++) begin
      push(0, {tag, "_hold"}, led_m);
      step();
      check();
    end
    led_m = dir ? {led_m[0], led_m[7:1]} : {led_m[6:0], led_m[7]};
    push(0, tag, led_m);
    step();
    check();
  endtask

  initial begin
    #2;
    push(0, "rst_led", 8'h00);
    push(1, "rst_seg", 8'h00);
    push(2, "rst_mode", 8'h00);
    push(3, "rst_full", 8'h00);
    check();
    #10 rst_n = 1'b1;
    step();
    // 1: insert 1,0,1 shifting left; parity of 0x05 is even
    ins(1'b1, "t1_a");
    ins(1'b0, "t1_b");
    ins(1'b1, "t1_c");
    push(0, "t1_led", 8'h05);
    push(3, "t1_full", 8'h00);
    check();
    push(1, "t1_seg", 8'h3F);
    step();
    check();
    // 2: fill to full, saturate, then clear
    clr();
    for (int i = 7; i >= 0; i--) begin
      ins(i[0] ^ i[2], "t2_fill");
      push(3, "t2_full_tr", (i == 0) ? 8'h01 : 8'h00);
      check();
    end
    ins(1'b1, "t2_ninth");
    push(3, "t2_full_sat", 8'h01);
    check();
    clr();
    // 3: build 0x81, rotate left twice, then right three times
    ins(1'b1, "t3_b");
    for (int i = 0; i < 6; i++) ins(1'b0, "t3_b");
    ins(1'b1, "t3_b");
    push(0, "t3_81", 8'h81);
    check();
    mode_press(1'b0, 2'b01, "t3_rot");
    rot_period("t3_l1");
    rot_period("t3_l2");
    push(0, "t3_06", 8'h06);
    check();
    dir = 1'b1;
    rot_period("t3_r1");
    rot_period("t3_r2");
    rot_period("t3_r3");
    push(0, "t3_c0", 8'hC0);
    check();
    // 4: freeze ignores bits; mode press beats a simultaneous bit press
    mode_press(1'b0, 2'b10, "t4_frz");
    b1 = 1'b1;
    push(0, "t4_frz_b1", led_m);
    step();
    b1 = 1'b0;
    b0 = 1'b1;
    push(0, "t4_frz_b0", led_m);
    step();
    b0 = 1'b0;
    check();
    mode_press(1'b0, 2'b00, "t4_shift");
    mode_press(1'b1, 2'b01, "t4_coinc");
    mode_press(1'b0, 2'b10, "t4_frz2");
    mode_press(1'b0, 2'b00, "t4_shift2");
    // 5: popcount digits and blanking
    dir = 1'b0;
    clr();
    for (int i = 0; i < 8; i++) ins(1'b1, "t5_ff");
    par = 1'b0;
    push(1, "t5_pop8", 8'h7F);
    step();
    check();
    dir = 1'b1;
    ins(1'b0, "t5_7f");
    push(1, "t5_pop7", 8'h07);
    step();
    check();
    segen = 1'b0;
    push(1, "t5_blank", 8'h00);
    step();
    check();
    segen = 1'b1;
    par = 1'b1;
    // 6: asynchronous reset in the middle of a rotate period
    dir = 1'b0;
    clr();
    for (int i = 0; i < 8; i++) ins((8'h5A >> (7 - i)) & 1, "t6_b");
    push(0, "t6_5a", 8'h5A);
    check();
    mode_press(1'b0, 2'b01, "t6_rot");
    step();
    #2 rst_n = 1'b0;
    #1;
    led_m = 8'h00;
    push(0, "t6_rst_led", 8'h00);
    push(2, "t6_rst_mode", 8'h00);
    push(1, "t6_rst_seg", 8'h00);
    push(3, "t6_rst_full", 8'h00);
    check();
    #3 rst_n = 1'b1;
    step();
    ins(1'b1, "t6_one");
    mode_press(1'b0, 2'b01, "t6_rot2");
    rot_period("t6_first_tick");
    push(0, "t6_02", 8'h02);
    check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
